// File: rtl/stereo_pkg.sv
// Shared image geometry, datapath widths and the pace FSM state type for the
// stereo disparity pipeline.
package stereo_pkg;

    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int ADDR_W = 17;
    localparam int SUM_W  = 25;
    localparam int CNT_W  = 17;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        DIVIDE,
        DONE
    } pace_state_t;

    // Clamp a wide quotient into the 8-bit disparity range.
    function automatic logic [7:0] saturate8(input logic [SUM_W-1:0] value);
        return (value > SUM_W'(255)) ? 8'hFF : value[7:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// o_done is high during the final iteration; the quotient is final the cycle after.
module seq_divider #(
    parameter int DVD_W = 25,
    parameter int DVS_W = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quotient
);

    localparam int BITS_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0]  r_quo;
    logic [DVS_W-1:0]  r_rem;
    logic [DVS_W-1:0]  r_dvs;
    logic [BITS_W-1:0] r_bitsLeft;
    logic              r_busy;
    logic [DVS_W:0]    w_remShift;
    logic [DVS_W-1:0]  w_remSub;
    logic              w_fits;

    assign w_remShift = {r_rem, r_quo[DVD_W-1]};
    assign w_fits     = w_remShift >= {1'b0, r_dvs};
    // When the divisor fits, the true difference is below the divisor, so the low bits suffice.
    assign w_remSub   = w_remShift[DVS_W-1:0] - r_dvs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_bitsLeft <= '0;
            r_busy     <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_quo      <= i_dividend;
            r_rem      <= '0;
            r_dvs      <= i_divisor;
            r_bitsLeft <= BITS_W'(DVD_W);
            r_busy     <= 1'b1;
        end else if (r_busy) begin
            r_quo      <= {r_quo[DVD_W-2:0], w_fits};
            r_rem      <= w_fits ? w_remSub : w_remShift[DVS_W-1:0];
            r_bitsLeft <= r_bitsLeft - BITS_W'(1);
            r_busy     <= (r_bitsLeft != BITS_W'(1));
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_bitsLeft == BITS_W'(1));
    assign o_quotient = r_quo;

endmodule

// File: rtl/disparity_pace.sv
// Scans a region of the SSD disparity BRAM, averages the nonzero disparities and
// turns the mean into a 4-bit LED pace code.
module disparity_pace #(
    parameter int IMG_W        = stereo_pkg::IMG_W,
    parameter int IMG_H        = stereo_pkg::IMG_H,
    parameter int ROI_X0       = 100,
    parameter int ROI_X1       = 219,
    parameter int ROI_Y0       = 80,
    parameter int ROI_Y1       = 159,
    parameter int MIN_COUNT    = 64,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    output logic [stereo_pkg::ADDR_W-1:0] addr_out,
    output logic                          rd_en_out,
    input  logic [7:0]                    dout_in,
    output logic                          busy_out,
    output logic [7:0]                    mean_out,
    output logic [stereo_pkg::CNT_W-1:0]  count_out,
    output logic [3:0]                    speed_out,
    output logic                          valid_out
);

    import stereo_pkg::*;

    localparam int X_LAST  = (ROI_X1 < IMG_W) ? ROI_X1 : IMG_W - 1;
    localparam int Y_LAST  = (ROI_Y1 < IMG_H) ? ROI_Y1 : IMG_H - 1;
    localparam int DRAIN_W = $clog2(BRAM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(ROI_Y0 * IMG_W + ROI_X0);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W - (X_LAST - ROI_X0));

    pace_state_t               r_state;
    pace_state_t               w_nextState;
    logic [15:0]               r_x;
    logic [15:0]               r_y;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_rdEn;
    logic [BRAM_LATENCY-1:0]   r_tag;
    logic [BRAM_LATENCY-1:0]   w_tagNext;
    logic [SUM_W-1:0]          r_sum;
    logic [CNT_W-1:0]          r_count;
    logic [DRAIN_W-1:0]        r_drainLeft;
    logic [7:0]                r_mean;
    logic [CNT_W-1:0]          r_countOut;
    logic [3:0]                r_speed;
    logic                      r_valid;
    logic                      w_lastPixel;
    logic                      w_take;
    logic [SUM_W-1:0]          w_sumNext;
    logic [CNT_W-1:0]          w_countNext;
    logic                      w_drainLast;
    logic                      w_enough;
    logic                      w_busy;
    logic                      w_accept;
    logic                      w_divStart;
    logic                      w_inScan;
    logic                      w_inDrain;
    logic                      w_inDone;
    logic                      w_divBusy;
    logic                      w_divDone;
    logic [SUM_W-1:0]          w_quotient;
    logic [7:0]                w_mean;

    // The tag pipeline mirrors the BRAM so each returning byte is known to be a real read.
    if (BRAM_LATENCY == 1) begin : g_tagSingle
        assign w_tagNext = r_rdEn;
    end else begin : g_tagShift
        assign w_tagNext = {r_tag[BRAM_LATENCY-2:0], r_rdEn};
    end

    assign w_lastPixel = (r_x == 16'(X_LAST)) && (r_y == 16'(Y_LAST));
    assign w_take      = r_tag[BRAM_LATENCY-1] && (dout_in != 8'd0);
    assign w_sumNext   = r_sum + (w_take ? SUM_W'(dout_in) : SUM_W'(0));
    assign w_countNext = r_count + CNT_W'(w_take);
    assign w_drainLast = (r_drainLeft == '0);
    assign w_enough    = (w_countNext >= CNT_W'(MIN_COUNT));
    assign w_mean      = (r_count >= CNT_W'(MIN_COUNT)) ? saturate8(w_quotient) : 8'd0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start_in) w_nextState = SCAN;
            SCAN:    if (w_lastPixel) w_nextState = DRAIN;
            DRAIN:   if (w_drainLast) w_nextState = w_enough ? DIVIDE : DONE;
            DIVIDE:  if (w_divDone || !w_divBusy) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b0;
        w_accept   = 1'b0;
        w_divStart = 1'b0;
        w_inScan   = 1'b0;
        w_inDrain  = 1'b0;
        w_inDone   = 1'b0;
        case (r_state)
            IDLE:   w_accept = start_in;
            SCAN:   begin w_busy = 1'b1; w_inScan = 1'b1; end
            DRAIN:  begin w_busy = 1'b1; w_inDrain = 1'b1; w_divStart = w_drainLast && w_enough; end
            DIVIDE: w_busy = 1'b1;
            DONE:   begin w_busy = 1'b1; w_inDone = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= '0;
            r_rdEn      <= 1'b0;
            r_tag       <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_drainLeft <= '0;
            r_mean      <= '0;
            r_countOut  <= '0;
            r_speed     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_tag       <= w_tagNext;
            r_drainLeft <= w_inDrain ? r_drainLeft - DRAIN_W'(1) : DRAIN_W'(BRAM_LATENCY - 1);
            r_valid     <= w_inDone;
            if (w_accept) begin
                r_x     <= 16'(ROI_X0);
                r_y     <= 16'(ROI_Y0);
                r_addr  <= START_ADDR;
                r_rdEn  <= 1'b1;
                r_sum   <= '0;
                r_count <= '0;
            end else begin
                r_sum   <= w_sumNext;
                r_count <= w_countNext;
                if (w_inScan) begin
                    if (w_lastPixel) begin
                        r_rdEn <= 1'b0;
                    end else if (r_x == 16'(X_LAST)) begin
                        r_x    <= 16'(ROI_X0);
                        r_y    <= r_y + 16'd1;
                        r_addr <= r_addr + ROW_STEP;
                    end else begin
                        r_x    <= r_x + 16'd1;
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
            end
            if (w_inDone) begin
                r_mean     <= w_mean;
                r_countOut <= r_count;
                r_speed    <= w_mean[7:4];
            end
        end
    end

    // Operands are the next-cycle accumulator values so the last drained byte is included.
    seq_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_divider (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_start    (w_divStart),
        .i_dividend (w_sumNext),
        .i_divisor  (w_countNext),
        .o_busy     (w_divBusy),
        .o_done     (w_divDone),
        .o_quotient (w_quotient)
    );

    assign addr_out  = r_addr;
    assign rd_en_out = r_rdEn;
    assign busy_out  = w_busy;
    assign mean_out  = r_mean;
    assign count_out = r_countOut;
    assign speed_out = r_speed;
    assign valid_out = r_valid;

endmodule
